// File: rtl/frogger_pkg.sv
// Shared Frogger definitions: game-level state encodings and the gameplay
// limits that the frog and car controllers also depend on.
package frogger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESPAWN   = 3'd1,
    ST_PLAY      = 3'd2,
    ST_HIT       = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_GAME_OVER = 3'd5
  } game_state_t;

  localparam int c_START_LIVES = 3;
  localparam int c_MAX_SCORE   = 99;
  localparam int c_MAX_LEVEL   = 7;

  // Saturating increment shared by the score and level counters.
  function automatic logic [6:0] sat_inc(input logic [6:0] val, input logic [6:0] lim);
    return (val >= lim) ? lim : val + 7'd1;
  endfunction

endpackage

// File: rtl/frogger_state_ctrl_rise_detect.sv
// Rising-edge detector: input registered once, edge = current & ~previous.
// The detector arms one cycle after reset, so a level already high at reset release is not an edge.
module rise_detect (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Sig,
  output logic o_Rise
);

  logic sig_q;
  logic armed_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sig_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sig_q   <= i_Sig;
      armed_q <= 1'b1;
    end
  end

  assign o_Rise = i_Sig & ~sig_q & armed_q;

endmodule

// File: rtl/frogger_state_ctrl.sv
// Game-level sequencer for Frogger: lives, level, score and the
// play / freeze / respawn / game-over state machine, timed by VSync frames.
//
// state        | meaning
// IDLE         | waiting for start, all controls low
// RESPAWN      | one-cycle respawn pulse to the frog
// PLAY         | frog movement enabled
// HIT          | frozen after collision for c_HIT_FRAMES frames
// LEVEL_UP     | frozen after level advance for c_LEVELUP_FRAMES frames
// GAME_OVER    | lives exhausted, score/level held until start
module frogger_state_ctrl #(
  parameter int c_START_LIVES     = frogger_pkg::c_START_LIVES,
  parameter int c_HIT_FRAMES      = 60,
  parameter int c_LEVELUP_FRAMES  = 90,
  parameter int c_GOALS_PER_LEVEL = 5,
  parameter int c_MAX_LEVEL       = frogger_pkg::c_MAX_LEVEL,
  parameter int c_MAX_SCORE       = frogger_pkg::c_MAX_SCORE
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_Collided,
  input  logic       i_Goal_Reached,
  output logic       o_Game_Active,
  output logic       o_Freeze,
  output logic       o_Respawn,
  output logic       o_Game_Over,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic [6:0] o_Score,
  output logic [2:0] o_State
);
  import frogger_pkg::*;

  localparam logic [1:0] LIVES_INIT = 2'(c_START_LIVES);
  localparam logic [7:0] HIT_LAST   = 8'(c_HIT_FRAMES - 1);
  localparam logic [7:0] LVUP_LAST  = 8'(c_LEVELUP_FRAMES - 1);
  localparam logic [3:0] GOALS_LAST = 4'(c_GOALS_PER_LEVEL - 1);
  localparam logic [6:0] LEVEL_MAX  = 7'(c_MAX_LEVEL);
  localparam logic [6:0] SCORE_MAX  = 7'(c_MAX_SCORE);

  game_state_t state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [2:0]  level_q, level_d;
  logic [6:0]  score_q, score_d;
  logic [3:0]  goals_q, goals_d;
  logic [7:0]  frame_q, frame_d;
  logic        reload;
  logic        vsync_rise;
  logic        start_rise;
  logic [6:0]  level_inc;

  rise_detect u_vsync_rise (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Sig  (i_VSync),
    .o_Rise (vsync_rise)
  );

  rise_detect u_start_rise (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Sig  (i_Game_Start),
    .o_Rise (start_rise)
  );

  assign level_inc = sat_inc({4'd0, level_q}, LEVEL_MAX);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      lives_q <= LIVES_INIT;
      level_q <= 3'd0;
      score_q <= 7'd0;
      goals_q <= 4'd0;
      frame_q <= 8'd0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      score_q <= score_d;
      goals_q <= goals_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    score_d = score_q;
    goals_d = goals_q;
    frame_d = frame_q;
    reload  = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          state_d = ST_RESPAWN;
          reload  = 1'b1;
        end
      end
      ST_RESPAWN: state_d = ST_PLAY;
      ST_PLAY: begin
        // Collision has priority; a simultaneous goal is dropped.
        if (i_Collided) begin
          state_d = ST_HIT;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end else if (i_Goal_Reached) begin
          score_d = sat_inc(score_q, SCORE_MAX);
          if (goals_q == GOALS_LAST) begin
            goals_d = 4'd0;
            level_d = level_inc[2:0];
            state_d = ST_LEVEL_UP;
          end else begin
            goals_d = goals_q + 4'd1;
            state_d = ST_RESPAWN;
          end
        end
      end
      ST_HIT: begin
        if (vsync_rise) begin
          frame_d = frame_q + 8'd1;
          if (frame_q == HIT_LAST)
            state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_RESPAWN;
        end
      end
      ST_LEVEL_UP: begin
        if (vsync_rise) begin
          frame_d = frame_q + 8'd1;
          if (frame_q == LVUP_LAST) state_d = ST_RESPAWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reload) begin
      lives_d = LIVES_INIT;
      level_d = 3'd0;
      score_d = 7'd0;
      goals_d = 4'd0;
    end

    if (state_d != state_q) frame_d = 8'd0;
  end

  assign o_Game_Active = (state_q == ST_PLAY);
  assign o_Freeze      = (state_q == ST_HIT) || (state_q == ST_LEVEL_UP);
  assign o_Respawn     = (state_q == ST_RESPAWN);
  assign o_Game_Over   = (state_q == ST_GAME_OVER);
  assign o_Lives       = lives_q;
  assign o_Level       = level_q;
  assign o_Score       = score_q;
  assign o_State       = state_q;

endmodule

// File: tb/tb_frogger_state_ctrl.sv
// Bench for frogger_state_ctrl: directed game scenarios plus random play,
// compared every cycle against a frame-countdown reference model.
module tb_frogger_state_ctrl;

  localparam int START = 3, HITF = 4, LUF = 3, GPL = 5, MAXL = 7, MAXS = 99;
  localparam int M_IDLE = 0, M_RESPAWN = 1, M_PLAY = 2, M_HIT = 3, M_LEVEL_UP = 4, M_GAME_OVER = 5;

  logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, start = 1'b0, collided = 1'b0, goal = 1'b0;
  logic game_active, freeze, respawn, game_over;
  logic [1:0] lives;
  logic [2:0] level;
  logic [6:0] score;
  logic [2:0] state;

  int n_checks = 0, n_pass = 0;
  int m_mode, m_lives, m_level, m_score, m_goals, m_left;
  bit m_vs_prev, m_st_prev, m_armed;

  always #5 clk = ~clk;

  frogger_state_ctrl #(
    .c_START_LIVES(START), .c_HIT_FRAMES(HITF), .c_LEVELUP_FRAMES(LUF),
    .c_GOALS_PER_LEVEL(GPL), .c_MAX_LEVEL(MAXL), .c_MAX_SCORE(MAXS)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_VSync(vsync), .i_Game_Start(start),
    .i_Collided(collided), .i_Goal_Reached(goal),
    .o_Game_Active(game_active), .o_Freeze(freeze), .o_Respawn(respawn),
    .o_Game_Over(game_over), .o_Lives(lives), .o_Level(level),
    .o_Score(score), .o_State(state)
  );

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference: one call per clock edge, using the inputs sampled at that edge.
  task automatic model_step();
    bit vs_e, st_e;
    if (rst) begin
      m_mode = M_IDLE; m_lives = START; m_level = 0; m_score = 0; m_goals = 0; m_left = 0;
      m_vs_prev = 0; m_st_prev = 0; m_armed = 0;
      return;
    end
    vs_e = vsync && !m_vs_prev && m_armed;
    st_e = start && !m_st_prev && m_armed;
    m_vs_prev = vsync; m_st_prev = start; m_armed = 1;
    case (m_mode)
      M_IDLE, M_GAME_OVER:
        if (st_e) begin
          m_mode = M_RESPAWN; m_lives = START; m_level = 0; m_score = 0; m_goals = 0;
        end
      M_RESPAWN: m_mode = M_PLAY;
      M_PLAY:
        if (collided) begin
          if (m_lives > 0) m_lives = m_lives - 1;
          m_mode = M_HIT; m_left = HITF;
        end else if (goal) begin
          m_score = (m_score < MAXS) ? m_score + 1 : MAXS;
          m_goals = m_goals + 1;
          if (m_goals == GPL) begin
            m_goals = 0;
            m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
            m_mode = M_LEVEL_UP; m_left = LUF;
          end else m_mode = M_RESPAWN;
        end
      M_HIT:
        if (vs_e) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = (m_lives == 0) ? M_GAME_OVER : M_RESPAWN;
        end
      M_LEVEL_UP:
        if (vs_e) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_RESPAWN;
        end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_mode);
    chk("game_active", int'(game_active), int'(m_mode == M_PLAY));
    chk("freeze", int'(freeze), int'(m_mode == M_HIT || m_mode == M_LEVEL_UP));
    chk("respawn", int'(respawn), int'(m_mode == M_RESPAWN));
    chk("game_over", int'(game_over), int'(m_mode == M_GAME_OVER));
    chk("lives", int'(lives), m_lives);
    chk("level", int'(level), m_level);
    chk("score", int'(score), m_score);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic frame();
    vsync = 1'b1; tick();
    vsync = 1'b0; repeat (3) tick();
  endtask

  task automatic start_game();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic collide_and_wait();
    collided = 1'b1; tick();
    collided = 1'b0;
    repeat (HITF) frame();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_state", int'(state), M_IDLE);
    chk("reset_lives", int'(lives), START);
    chk("reset_respawn", int'(respawn), 0);
    rst = 1'b0;
    repeat (6) tick();

    // Start: respawn for exactly one cycle, then play.
    start = 1'b1; tick();
    start = 1'b0;
    chk("start_respawn", int'(respawn), 1);
    tick();
    chk("start_play", int'(state), M_PLAY);
    chk("start_lives", int'(lives), 3);
    chk("start_score", int'(score), 0);

    // Collision: lives drop immediately, freeze for HITF frames.
    collided = 1'b1; tick();
    collided = 1'b0;
    chk("hit_lives", int'(lives), 2);
    chk("hit_freeze", int'(freeze), 1);
    repeat (HITF - 1) frame();
    chk("hit_still_frozen", int'(freeze), 1);
    vsync = 1'b1; tick(); vsync = 1'b0;
    chk("hit_exit_respawn", int'(respawn), 1);
    repeat (3) tick();

    // Two more collisions end the game; start reloads.
    collide_and_wait();
    collide_and_wait();
    chk("go_state", int'(state), M_GAME_OVER);
    chk("go_flag", int'(game_over), 1);
    chk("go_lives", int'(lives), 0);
    start_game();
    chk("restart_lives", int'(lives), 3);
    chk("restart_score", int'(score), 0);

    // Goal then simultaneous collision+goal: collision wins.
    goal = 1'b1; tick(); goal = 1'b0; tick();
    chk("goal_score", int'(score), 1);
    collided = 1'b1; goal = 1'b1; tick();
    collided = 1'b0; goal = 1'b0;
    chk("both_state", int'(state), M_HIT);
    chk("both_score", int'(score), 1);
    chk("both_lives", int'(lives), 2);
    repeat (HITF) frame();

    // Random play, including stray starts and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      vsync    = ($urandom_range(0, 2) == 0);
      start    = ($urandom_range(0, 15) == 0);
      collided = ($urandom_range(0, 30) == 0);
      goal     = !goal && ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; collided = 1'b0; goal = 1'b0; vsync = 1'b0;

    // Long goal run to saturate level and score.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    start_game();
    for (int i = 0; i < 2500; i++) begin
      vsync = ($urandom_range(0, 2) == 0);
      goal  = !goal && ($urandom_range(0, 1) == 0);
      tick();
    end
    goal = 1'b0; vsync = 1'b0;
    chk("sat_level", int'(level), MAXL);
    chk("sat_score", int'(score), MAXS);

    // Reset during HIT with start held across release.
    repeat (12) frame();
    collided = 1'b1; tick(); collided = 1'b0; tick();
    chk("pre_reset_freeze", int'(freeze), 1);
    rst = 1'b1; start = 1'b1; tick();
    chk("rst_state", int'(state), M_IDLE);
    chk("rst_respawn", int'(respawn), 0);
    chk("rst_score", int'(score), 0);
    rst = 1'b0;
    repeat (5) tick();
    chk("held_start_idle", int'(state), M_IDLE);
    start = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frogger_state_ctrl.md
# frogger_state_ctrl

Game-level sequencer for the Frogger datapath: owns lives, level, score and the play/freeze/respawn/game-over state machine. Sits beside `frogger_game`, consuming the collision flag and goal-reached pulse and driving game-active, freeze and respawn controls back into the frog and car controllers. It is also the single source of the score shown on the 7-segment displays. Frame-based timing is derived from `i_VSync`.

## Interface
- c_START_LIVES, 3, lives loaded on game start (1..3)
- c_HIT_FRAMES, 60, freeze length after a collision, in frames (1..255)
- c_LEVELUP_FRAMES, 90, freeze length on level-up, in frames (1..255)
- c_GOALS_PER_LEVEL, 5, goals needed to advance a level (1..15)
- c_MAX_LEVEL, 7, level saturation value (≤7)
- c_MAX_SCORE, 99, score saturation value (≤127)

- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous, active-high reset
- i_VSync  in  1  vertical sync; rising edge = one frame tick
- i_Game_Start  in  1  start button (debounced externally), rising edge used
- i_Collided  in  1  level: frog overlaps a car
- i_Goal_Reached  in  1  one-cycle pulse: frog reached a lily pad
- o_Game_Active  out  1  frog movement enabled
- o_Freeze  out  1  cars and frog hold position
- o_Respawn  out  1  one-cycle pulse: return frog to start tile
- o_Game_Over  out  1  high in GAME_OVER
- o_Lives  out  2  remaining lives
- o_Level  out  3  current level (selects car speed)
- o_Score  out  7  binary score 0..c_MAX_SCORE
- o_State  out  3  state encoding, for debug/LED

## Operation
- States: IDLE=0, RESPAWN=1, PLAY=2, HIT=3, LEVEL_UP=4, GAME_OVER=5; 6,7 unreachable, recover to IDLE.
- IDLE: all controls low. Start edge → RESPAWN; lives=c_START_LIVES, level=0, score=0, goal count=0.
- RESPAWN: exactly one cycle, o_Respawn=1 → PLAY.
- PLAY: o_Game_Active=1. i_Collided high → HIT, lives decremented on transition. Else i_Goal_Reached → score+1 (saturate c_MAX_SCORE), goals+1; if goals reach c_GOALS_PER_LEVEL → LEVEL_UP (goals=0, level+1 saturating at c_MAX_LEVEL), else → RESPAWN.
- Collision and goal in the same cycle: collision wins, goal dropped, score unchanged.
- HIT: o_Freeze=1; frame counter cleared on entry; after c_HIT_FRAMES frame ticks → GAME_OVER if lives==0, else RESPAWN.
- LEVEL_UP: o_Freeze=1; after c_LEVELUP_FRAMES ticks → RESPAWN.
- GAME_OVER: o_Game_Over=1, lives=0, score/level held. Start edge → RESPAWN with the same reload as IDLE.
- Start edges outside IDLE/GAME_OVER ignored. i_Collided/i_Goal_Reached ignored outside PLAY.
- Lives never underflow: decrement only when nonzero.
- Frame counter 8 bits, cleared on every state entry.

## Timing
- Edge detectors: input registered once; edge flagged in cycle N when current=1, previous=0.
- All outputs registered / decoded from registered state: decision at edge N, outputs change after edge N+1.
- Start edge at N → o_Respawn high for exactly cycle N+1 → o_Game_Active high from N+2.
- Collision sampled at N → o_Freeze high and o_Lives decremented from N+1.
- Freeze exit: cycle after the c_HIT_FRAMES-th tick counted in HIT, state = RESPAWN.
- Reset: state IDLE, o_Lives=c_START_LIVES, o_Level=0, o_Score=0, all 1-bit outputs 0, edge registers 0. Reset mid-game takes effect at the next clock edge with no o_Respawn pulse; an i_Game_Start held high through reset does not start a game.

## Structure
- Package `frogger_pkg`: state encodings, c_START_LIVES, c_MAX_SCORE, c_MAX_LEVEL; shared with frog/car controllers.
- One sub-module: `rise_detect` (register + AND-NOT), instantiated for i_VSync and i_Game_Start.
- Remainder: single FSM process plus lives/level/score/goal/frame counters.

## Test plan
- Reset, then start pulse at cycle 10 → o_Respawn=1 only in cycle 11, o_State=PLAY at 12, o_Lives=3, o_Score=0.
- In PLAY assert i_Collided with c_HIT_FRAMES=4 → o_Lives 3→2 next cycle, o_Freeze high for exactly 4 VSync edges, then one o_Respawn pulse.
- Three collisions → after third freeze o_State=GAME_OVER, o_Game_Over=1, o_Lives=0; start edge → o_Lives=3, o_Score=0.
- Five goal pulses (c_GOALS_PER_LEVEL=5) → o_Score=5, o_Level=1, LEVEL_UP freeze of c_LEVELUP_FRAMES frames; goals from level 7 leave o_Level=7; score preloaded to 99 stays 99.
- i_Collided and i_Goal_Reached together → HIT, o_Score unchanged, o_Lives-1.
- i_Rst during HIT → IDLE next cycle, outputs at reset values, no o_Respawn; i_Game_Start held high across reset release → stays IDLE.
